// File: rtl/mcu_pkg.sv
// Shared encodings for the MCU condition selector: request modes and FSM states.
package mcu_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_WAIT = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cond_sel_seq_lane_mux.sv
// Combinational lane selector; out-of-range selects yield zero and in_range_o = 0.
module lane_mux #(
  parameter int SEL_W  = 4,
  parameter int NUM_IN = 16,
  parameter int DATA_W = 1
) (
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_IN*DATA_W-1:0] flags_i,
  output logic [DATA_W-1:0]        lane_o,
  output logic                     in_range_o
);

  always_comb begin
    lane_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_i == SEL_W'(i)) lane_o = flags_i[i*DATA_W +: DATA_W];
    end
  end

  assign in_range_o = ({1'b0, sel_i} < (SEL_W+1)'(NUM_IN));

endmodule

// File: rtl/cond_sel_seq.sv
// Registered flag-lane selector with PASS/INV/WAIT modes, wait timeout and
// valid/ready request and response handshakes.
module cond_sel_seq
  import mcu_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int NUM_IN = 16,
  parameter int DATA_W = 1,
  parameter int TMO_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic [1:0]               req_mode,
  input  logic [TMO_W-1:0]         req_tmo,
  input  logic [NUM_IN*DATA_W-1:0] flags,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_err,
  output logic                     resp_tmo
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  mode_e               mode_q, mode_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                rtmo_q, rtmo_d;

  logic [SEL_W-1:0]    mux_sel;
  logic [DATA_W-1:0]   lane;
  logic                in_range;
  mode_e               req_mode_e;

  // While idle the mux follows the incoming request; afterwards the latched lane.
  assign mux_sel    = (state_q == IDLE) ? req_sel : sel_q;
  assign req_mode_e = mode_e'(req_mode);

  lane_mux #(
    .SEL_W (SEL_W),
    .NUM_IN(NUM_IN),
    .DATA_W(DATA_W)
  ) u_lane_mux (
    .sel_i     (mux_sel),
    .flags_i   (flags),
    .lane_o    (lane),
    .in_range_o(in_range)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    rtmo_d  = rtmo_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          sel_d  = req_sel;
          mode_d = req_mode_e;
          tmo_d  = req_tmo;
          cnt_d  = '0;
          if (req_mode_e == MODE_WAIT && in_range) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rtmo_d  = 1'b0;
            err_d   = !in_range || (req_mode_e == MODE_RSVD);
            if (!in_range)                    data_d = '0;
            else if (req_mode_e == MODE_INV)  data_d = ~lane;
            else                              data_d = lane;
          end
        end
      end
      WAIT: begin
        if (mode_q != MODE_WAIT) begin
          // Unreachable in normal operation; recover with an error response.
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
          rtmo_d  = 1'b0;
        end else if (lane != '0) begin
          state_d = RESP;
          data_d  = lane;
          err_d   = 1'b0;
          rtmo_d  = 1'b0;
        end else if (tmo_q != '0 && cnt_q == tmo_q - TMO_W'(1)) begin
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b0;
          rtmo_d  = 1'b1;
        end else if (cnt_q != {TMO_W{1'b1}}) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mode_q  <= MODE_PASS;
      tmo_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rtmo_q  <= rtmo_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign resp_tmo   = rtmo_q;

endmodule

// File: doc/cond_sel_seq.md
Name: cond_sel_seq

Overview:
- Parametrised, registered successor to the 16:1 flag selector in the MCU datapath.
- Selects one of NUM_IN flag lanes by a SEL_W-bit opcode field under a valid/ready request handshake.
- Supports pass, invert and wait-until-true modes, with a timeout counter.
- Feeds the branch/condition logic of the MCU control unit.
- Out-of-range selects return a defined error; they never produce X.

Parameters:
- SEL_W, 4, select field width.
- NUM_IN, 16, number of flag lanes; legal range 2..2**SEL_W.
- DATA_W, 1, width of each lane.
- TMO_W, 8, width of the wait-timeout counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  SEL_W  lane index.
- req_mode  in  2  0 = PASS, 1 = INV, 2 = WAIT, 3 = reserved (treated as PASS, err set).
- req_tmo  in  TMO_W  WAIT timeout in cycles; 0 means no timeout.
- flags  in  NUM_IN*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  selected value, after mode processing.
- resp_err  out  1  bad select or reserved mode.
- resp_tmo  out  1  WAIT ended by timeout.

Behaviour:
- Reset (synchronous, active-high), applied on the next clk edge:
  - state = IDLE, req_ready = 1, resp_valid = 0.
  - resp_data = 0, resp_err = 0, resp_tmo = 0.
  - Timeout counter = 0, latched sel/mode = 0.
- Reset mid-operation aborts any WAIT or pending response; no response is emitted for the aborted request.
- State machine (IDLE, WAIT, RESP):
  - IDLE: req_ready = 1. A request is accepted when req_valid and req_ready are both 1. On acceptance, latch sel, mode and tmo.
    - PASS, INV, reserved mode, or any out-of-range select: next state RESP. resp_data is computed from flags in the acceptance cycle. Latency is 1 clk (resp_valid is high on the cycle after acceptance).
    - WAIT with a valid select: next state WAIT, counter = 0.
  - WAIT: req_ready = 0. Each cycle, sample the latched lane.
    - Lane is non-zero: go to RESP with resp_data = lane value, resp_tmo = 0.
    - Otherwise, if tmo != 0 and counter == tmo-1: go to RESP with resp_data = 0, resp_tmo = 1.
    - Otherwise increment the counter. The counter saturates at all-ones when tmo = 0 and never wraps.
    - Minimum WAIT latency is 2 clk from acceptance.
  - RESP: resp_valid = 1, req_ready = 0. All resp_* signals are held stable until resp_valid and resp_ready are both 1, then go to IDLE.
    - No back-to-back bypass: after a response completes, req_ready reasserts on the next cycle.
- Mode processing:
  - PASS: data = lane.
  - INV: data = ~lane (bitwise over DATA_W).
  - Reserved mode: data = lane, err = 1.
- Out-of-range select (sel >= NUM_IN): resp_data = 0 and resp_err = 1 in every mode, including WAIT, which does not enter the WAIT state.
- Flags are sampled live each cycle and are not latched at acceptance, except for the value captured when entering RESP.
- resp_err and resp_tmo are never both 1.
- resp_err is always 0 when NUM_IN = 2**SEL_W and the mode is not reserved.

Decomposition:
- Shared package (mcu_pkg) holds:
  - Mode encodings MODE_PASS, MODE_INV, MODE_WAIT, MODE_RSVD.
  - The state enum IDLE, WAIT, RESP.
- One sub-module, lane_mux: purely combinational, parametrised NUM_IN/DATA_W/SEL_W. Outputs the lane value and an in_range flag.
- cond_sel_seq wraps lane_mux with the FSM, timeout counter and response registers.

Test Plan:
- Reset then idle: assert rst for 2 cycles with req_valid = 1 -> req_ready = 1, resp_valid = 0, and all resp_* = 0 the cycle after rst falls.
- PASS/INV, default params, flags = 16'hA5C3:
  - sel = 0, PASS -> resp_data = 1 one cycle later.
  - sel = 2, INV -> resp_data = 1.
  - sel = 15, PASS -> resp_data = 1; resp_err = 0 in all three.
- Backpressure: hold resp_ready = 0 for 5 cycles during a PASS response -> resp_valid and resp_data stay stable and req_ready = 0. Complete with resp_ready = 1, then the next request is accepted exactly 1 cycle later.
- WAIT success: sel = 3, tmo = 10, flags[3] = 0 for 4 cycles then 1 -> resp_data = 1, resp_tmo = 0, resp_valid rises the cycle after flags[3] rises.
- WAIT timeout: sel = 5, tmo = 3, flags[5] held at 0 -> resp_valid with resp_tmo = 1, resp_data = 0, 4 cycles after acceptance.
- Errors:
  - NUM_IN = 12, sel = 13, WAIT -> resp_err = 1, resp_data = 0 one cycle later, no WAIT entered.
  - mode = 3 -> resp_err = 1, resp_data = lane value.
  - rst asserted mid-WAIT -> IDLE next cycle, no response emitted.
